// File: rtl/pht_update_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module : pht_update_queue_pkg
// Brief  : Shared fetch-unit types for PHT counter updates.
// Rev    : 1.0  initial release
// ============================================================================
package pht_update_queue_pkg;

  localparam int PHT_UPDATE_QUEUE_ENTRY_NUM = 8;
  localparam int PHT_INDEX_WIDTH            = 10;
  localparam int PHT_CTR_WIDTH              = 2;

  typedef struct packed {
    logic [PHT_INDEX_WIDTH-1:0] index;
    logic [PHT_CTR_WIDTH-1:0]   value;
  } PHT_UpdateEntry;

  // Width-generic saturating counter step; callers cast the result back.
  function automatic int unsigned sat_ctr_next(input int unsigned prev,
                                               input logic        taken,
                                               input int unsigned width);
    int unsigned max_val;
    max_val = (32'd1 << width) - 32'd1;
    if (taken) return (prev >= max_val) ? max_val : prev + 32'd1;
    else       return (prev == 32'd0)   ? 32'd0   : prev - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pht_update_queue_ram.sv
`default_nettype none
// ============================================================================
// Module : pht_update_queue_ram
// Brief  : ENTRY_NUM-deep register file, multi-port write, async read.
// Rev    : 1.0  initial release
// ============================================================================
module pht_update_queue_ram #(
  parameter int ENTRY_NUM = 8,
  parameter int PORT_NUM  = 2,
  parameter int ENTRY_W   = 12
) (
  input  logic                                       clk,
  input  logic [PORT_NUM-1:0]                        we,
  input  logic [PORT_NUM-1:0][$clog2(ENTRY_NUM)-1:0] waddr,
  input  logic [PORT_NUM-1:0][ENTRY_W-1:0]           wdata,
  input  logic [PORT_NUM-1:0][$clog2(ENTRY_NUM)-1:0] raddr,
  output logic [PORT_NUM-1:0][ENTRY_W-1:0]           rdata
);

  logic [ENTRY_W-1:0] r_mem [ENTRY_NUM];

  // Write addresses are distinct within a cycle by construction of the caller.
  always_ff @(posedge clk) begin
    for (int i = 0; i < PORT_NUM; i++) begin
      if (we[i]) r_mem[waddr[i]] <= wdata[i];
    end
  end

  generate
    for (genvar k = 0; k < PORT_NUM; k++) begin : g_rd
      assign rdata[k] = r_mem[raddr[k]];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pht_update_queue.sv
`default_nettype none
// ============================================================================
// Module : pht_update_queue
// Brief  : Buffers resolved branch counter updates, drains bank-safe pairs.
// Rev    : 1.0  initial release
// ============================================================================
module pht_update_queue
  import pht_update_queue_pkg::*;
#(
  parameter int ENTRY_NUM      = PHT_UPDATE_QUEUE_ENTRY_NUM,
  parameter int IN_WIDTH       = 2,
  parameter int INDEX_WIDTH    = PHT_INDEX_WIDTH,
  parameter int CTR_WIDTH      = PHT_CTR_WIDTH,
  parameter int DROP_CNT_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [IN_WIDTH-1:0]                   in_valid,
  input  logic [IN_WIDTH-1:0][INDEX_WIDTH-1:0]  in_index,
  input  logic [IN_WIDTH-1:0][CTR_WIDTH-1:0]    in_prev_ctr,
  input  logic [IN_WIDTH-1:0]                   in_taken,
  input  logic                                  hold,
  output logic [IN_WIDTH-1:0]                   out_we,
  output logic [IN_WIDTH-1:0][INDEX_WIDTH-1:0]  out_wa,
  output logic [IN_WIDTH-1:0][CTR_WIDTH-1:0]    out_wv,
  output logic [$clog2(ENTRY_NUM):0]            count,
  output logic [DROP_CNT_WIDTH-1:0]             drop_cnt
);

  localparam int PTR_W   = $clog2(ENTRY_NUM);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = INDEX_WIDTH + CTR_WIDTH;

  logic [CNT_W-1:0]                     r_head;
  logic [CNT_W-1:0]                     r_tail;
  logic [CNT_W-1:0]                     w_free;
  logic [IN_WIDTH-1:0]                  w_req;
  logic [IN_WIDTH-1:0][CTR_WIDTH-1:0]   w_next_ctr;
  logic [IN_WIDTH-1:0]                  w_wr_en;
  logic [IN_WIDTH-1:0][PTR_W-1:0]       w_wr_addr;
  logic [IN_WIDTH-1:0][ENTRY_W-1:0]     w_wr_data;
  logic [CNT_W-1:0]                     w_acc_num;
  logic [CNT_W-1:0]                     w_rej_num;
  logic [DROP_CNT_WIDTH:0]              w_drop_sum;
  logic [DROP_CNT_WIDTH-1:0]            w_drop_next;
  logic [IN_WIDTH-1:0][PTR_W-1:0]       w_rd_addr;
  logic [IN_WIDTH-1:0][ENTRY_W-1:0]     w_rd_data;
  logic [IN_WIDTH-1:0]                  w_sel;
  logic [CNT_W-1:0]                     w_sel_num;
  logic                                 w_blocked;
  logic                                 w_clash;

  assign count  = r_tail - r_head;
  assign w_free = CNT_W'(ENTRY_NUM) - count;

  generate
    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_next
      assign w_next_ctr[i] = CTR_WIDTH'(sat_ctr_next(32'(in_prev_ctr[i]), in_taken[i], CTR_WIDTH));
    end
  endgenerate

  // A younger port with the same index supersedes an older one this cycle.
  always_comb begin
    w_req = in_valid;
    for (int i = 0; i < IN_WIDTH; i++) begin
      for (int j = i + 1; j < IN_WIDTH; j++) begin
        if (in_valid[j] && (in_index[i] == in_index[j])) w_req[i] = 1'b0;
      end
    end
  end

  always_comb begin
    w_acc_num = '0;
    w_rej_num = '0;
    w_wr_en   = '0;
    w_wr_addr = '0;
    w_wr_data = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      w_wr_addr[i] = PTR_W'(r_tail + w_acc_num);
      w_wr_data[i] = {in_index[i], w_next_ctr[i]};
      if (w_req[i]) begin
        if (w_free > w_acc_num) begin
          w_wr_en[i] = 1'b1;
          w_acc_num  = w_acc_num + CNT_W'(1);
        end else begin
          w_rej_num  = w_rej_num + CNT_W'(1);
        end
      end
    end
  end

  assign w_drop_sum  = {1'b0, drop_cnt} + (DROP_CNT_WIDTH+1)'(w_rej_num);
  assign w_drop_next = w_drop_sum[DROP_CNT_WIDTH] ? '1 : w_drop_sum[DROP_CNT_WIDTH-1:0];

  // In-order drain: the first slot that cannot issue stops all later slots.
  always_comb begin
    w_sel     = '0;
    w_sel_num = '0;
    w_blocked = hold;
    w_clash   = 1'b0;
    w_rd_addr = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      w_rd_addr[k] = PTR_W'(r_head + CNT_W'(k));
    end
    for (int k = 0; k < IN_WIDTH; k++) begin
      w_clash = 1'b0;
      for (int m = 0; m < k; m++) begin
        if (w_rd_data[m][CTR_WIDTH] == w_rd_data[k][CTR_WIDTH]) w_clash = 1'b1;
      end
      if (!w_blocked && (count > CNT_W'(k)) && !w_clash) begin
        w_sel[k]  = 1'b1;
        w_sel_num = w_sel_num + CNT_W'(1);
      end else begin
        w_blocked = 1'b1;
      end
    end
  end

  pht_update_queue_ram #(
    .ENTRY_NUM (ENTRY_NUM),
    .PORT_NUM  (IN_WIDTH),
    .ENTRY_W   (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (w_wr_en),
    .waddr (w_wr_addr),
    .wdata (w_wr_data),
    .raddr (w_rd_addr),
    .rdata (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      drop_cnt <= '0;
      out_we   <= '0;
      out_wa   <= '0;
      out_wv   <= '0;
    end else begin
      r_tail   <= r_tail + w_acc_num;
      r_head   <= r_head + w_sel_num;
      drop_cnt <= w_drop_next;
      out_we   <= w_sel;
      for (int k = 0; k < IN_WIDTH; k++) begin
        if (w_sel[k]) begin
          out_wa[k] <= w_rd_data[k][ENTRY_W-1:CTR_WIDTH];
          out_wv[k] <= w_rd_data[k][CTR_WIDTH-1:0];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/pht_update_queue.md
Name: pht_update_queue

Overview:
- Sits between the integer-execute branch-resolution ports and the PAg/PAp counter table write ports.
- Buffers resolved conditional-branch counter updates and computes the 2-bit saturating next value.
- Drains up to two updates per cycle, never issuing two writes to the same bank in one cycle.
- Removes today's silent drop of write port 1 on same-address or same-bank collision.

Parameters:
- ENTRY_NUM, 8, queue depth; power of two, at least 4.
- IN_WIDTH, 2, branch-result ports per cycle; equals INT_ISSUE_WIDTH.
- INDEX_WIDTH, 10, counter-table index width.
- CTR_WIDTH, 2, saturating counter width.
- DROP_CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  [IN_WIDTH]  resolved conditional branch present
- in_index  in  [IN_WIDTH][INDEX_WIDTH]  counter-table index of the branch
- in_prev_ctr  in  [IN_WIDTH][CTR_WIDTH]  counter value read at prediction time
- in_taken  in  [IN_WIDTH]  resolved direction
- hold  in  1  table busy (predictor reset sequence); suppresses drain
- out_we  out  [IN_WIDTH]  table write enable
- out_wa  out  [IN_WIDTH][INDEX_WIDTH]  table write address
- out_wv  out  [IN_WIDTH][CTR_WIDTH]  table write value
- count  out  clog2(ENTRY_NUM)+1  valid entries in the queue
- drop_cnt  out  DROP_CNT_WIDTH  updates lost to a full queue, saturating

Behaviour:
- Reset: on rst high at a clock edge, the following are cleared:
  - head, tail, count, drop_cnt all go to 0;
  - out_we goes to all 0; out_wa and out_wv go to 0.
  - rst asserted mid-operation discards all queued entries. No write issues in the cycle after the reset edge.
- Next value, computed at enqueue:
  - taken: saturating increment, capped at 2^CTR_WIDTH-1.
  - not taken: saturating decrement, floored at 0.
  - Stored entry = {index, next value}.
- Same-cycle coalescing: if in_valid[0] and in_valid[1] are both set and the indices are equal, only port 1 is enqueued. Port 1 is the younger update; it counts as one entry.
- Enqueue order: port 0 before port 1.
- Space check: free = ENTRY_NUM - count, where count is the value at the start of the cycle; same-cycle dequeues are not credited.
  - Port 0 is accepted if free ≥ 1.
  - Port 1 is accepted if free ≥ (port 0 accepted ? 2 : 1).
  - Each rejected valid input increments drop_cnt by 1, saturating; two rejects in one cycle add 2.
- Drain selection, combinational on the start-of-cycle queue state, suppressed while hold = 1:
  - Slot 0 takes head if count ≥ 1.
  - Slot 1 takes head+1 if count ≥ 2 and index[0] of head+1 differs from index[0] of head. Bank = index LSB.
  - Otherwise slot 1 stays idle; the entry waits, preserving order.
- Output register: the selected entries are registered into out_we/out_wa/out_wv, so a write appears in the cycle after selection. Head advances by the number selected.
  - out_we is deasserted in any cycle that follows no selection; stale out_wa/out_wv are don't-care.
- Latency: an input valid in cycle N is in the queue in N+1 and appears on out_we in N+2 at the earliest (queue empty, hold low).
- Pointer wrap: modulo ENTRY_NUM. count = tail - head, with an extra MSB to distinguish full from empty.
- Simultaneous enqueue and dequeue: both happen in the same cycle; count += accepted - drained.
- No flush input: updates come from resolved branches and are non-speculative.
- Same-index entries queued in different cycles each write their own precomputed value in order. The last write wins; read-modify-write merging is not required.

Decomposition:
- Shared package FetchUnitTypes holds:
  - PHT_UpdateEntry struct {index, value};
  - PHT_UPDATE_QUEUE_ENTRY_NUM.
- Saturating increment/decrement is a package function reused by the predictors.
- One sub-module: pht_update_queue_ram, the ENTRY_NUM x entry register file with 2 write and 2 read ports. Pointer, count, drain logic and output register stay in the top module.

Test Plan:
- Single update, then drain: empty queue; cycle 0: port 0 valid, index 0x005, prev 1, taken.
  - Cycle 2: out_we = 01, out_wa[0] = 0x005, out_wv[0] = 2. count returns to 0.
- Saturation: prev 3 taken gives out_wv 3; prev 0 not taken gives out_wv 0.
- Coalescing: both ports index 0x010; port 0 taken with prev 1, port 1 not taken with prev 1.
  - Exactly one write: wa 0x010, wv 0. count peaks at 1.
- Bank conflict: enqueue indices 0x002 and 0x004 in one cycle. Two cycles later only slot 0 writes 0x002; 0x004 writes the next cycle.
  - Indices 0x002 and 0x003 instead write together in one cycle.
- Full/drop: with hold = 1, offer 5 cycles of 2 valid inputs, distinct indices.
  - count = 8, drop_cnt = 2.
  - Release hold: 8 writes emerge in enqueue order, at most 2 per cycle.
- Reset mid-operation: 6 entries queued, assert rst for one cycle.
  - count = 0, drop_cnt = 0, and out_we = 0 for the following cycle and until new input arrives.
